// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-master SRAM port-A arbiter.
package sram_arb_pkg;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   is_read;
        logic   err;
    } pend_t;

    // Number of byte-offset bits below the word index.
    function automatic int align_off(input int datawidth);
        return $clog2(datawidth / 8);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; rr_last remembers who was served most recently.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    owner_e rr_last;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_last == OWN_M0) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only.
    // rr_last resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= OWN_M1;
        end else if (advance && (gnt != 2'b00)) begin
            rr_last <= gnt[1] ? OWN_M1 : OWN_M0;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port A between instruction fetch (m0) and loader/debug (m1):
// round-robin grant, byte-to-word translation, range check, response routing.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int          DATAWIDTH = 32,
    parameter int          ADDRWIDTH = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m0_req,
    output logic                   m0_gnt,
    input  logic [31:0]            m0_addr,
    input  logic                   m0_we,
    input  logic [DATAWIDTH/8-1:0] m0_be,
    input  logic [DATAWIDTH-1:0]   m0_wdata,
    output logic                   m0_rvalid,
    output logic [DATAWIDTH-1:0]   m0_rdata,
    output logic                   m0_err,
    input  logic                   m1_req,
    output logic                   m1_gnt,
    input  logic [31:0]            m1_addr,
    input  logic                   m1_we,
    input  logic [DATAWIDTH/8-1:0] m1_be,
    input  logic [DATAWIDTH-1:0]   m1_wdata,
    output logic                   m1_rvalid,
    output logic [DATAWIDTH-1:0]   m1_rdata,
    output logic                   m1_err,
    output logic [ADDRWIDTH-1:0]   sram_addr,
    output logic                   sram_we,
    output logic [DATAWIDTH/8-1:0] sram_be,
    output logic [DATAWIDTH-1:0]   sram_d,
    input  logic [DATAWIDTH-1:0]   sram_q
);

    localparam int          AL    = align_off(DATAWIDTH);
    localparam int          ABITS = ADDRWIDTH + AL;
    localparam logic [32:0] LIMIT = 33'd1 << ABITS;

    logic [1:0]           gnt;
    logic                 any_gnt;
    logic [31:0]          addr_mux;
    logic                 we_mux;
    logic [31:0]          off;
    logic                 oor;
    logic [ADDRWIDTH-1:0] addr_hold;
    logic [DATAWIDTH-1:0] resp_data;
    pend_t                pend_q;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({m1_req, m0_req}),
        .advance (m0_req | m1_req),
        .gnt     (gnt)
    );

    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];
    assign any_gnt = |gnt;

    assign addr_mux = gnt[1] ? m1_addr : m0_addr;
    assign we_mux   = gnt[1] ? m1_we   : m0_we;
    assign sram_be  = gnt[1] ? m1_be   : m0_be;
    assign sram_d   = gnt[1] ? m1_wdata : m0_wdata;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the same check.
    assign off = addr_mux - BASE_ADDR;
    assign oor = ({1'b0, off} >= LIMIT);

    assign sram_addr = any_gnt ? off[ABITS-1:AL] : addr_hold;
    assign sram_we   = any_gnt & we_mux & ~oor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold <= '0;
            pend_q    <= '0;
        end else begin
            if (any_gnt) begin
                addr_hold <= off[ABITS-1:AL];
            end
            pend_q.valid   <= any_gnt;
            pend_q.owner   <= gnt[1] ? OWN_M1 : OWN_M0;
            pend_q.is_read <= ~we_mux;
            pend_q.err     <= oor;
        end
    end

    // Writes and errored accesses return zero data.
    assign resp_data = (pend_q.is_read && !pend_q.err) ? sram_q : '0;

    assign m0_rvalid = pend_q.valid && (pend_q.owner == OWN_M0);
    assign m1_rvalid = pend_q.valid && (pend_q.owner == OWN_M1);
    assign m0_rdata  = m0_rvalid ? resp_data : '0;
    assign m1_rdata  = m1_rvalid ? resp_data : '0;
    assign m0_err    = m0_rvalid && pend_q.err;
    assign m1_err    = m1_rvalid && pend_q.err;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: two arbiters (BASE 0 and BASE 0x1000_0000), each on a write-first SRAM model.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;

    logic        lo_m0_gnt, lo_m1_gnt, lo_m0_rvalid, lo_m1_rvalid, lo_m0_err, lo_m1_err, lo_sram_we;
    logic [31:0] lo_m0_rdata, lo_m1_rdata, lo_sram_d, lo_q;
    logic [3:0]  lo_sram_be;
    logic [11:0] lo_sram_addr;
    logic        hi_m0_gnt, hi_m1_gnt, hi_m0_rvalid, hi_m1_rvalid, hi_m0_err, hi_m1_err, hi_sram_we;
    logic [31:0] hi_m0_rdata, hi_m1_rdata, hi_sram_d, hi_q;
    logic [3:0]  hi_sram_be;
    logic [11:0] hi_sram_addr;

    logic        bd_we, bd_sel;
    logic [11:0] bd_addr;
    logic [31:0] bd_data;
    logic [31:0] lo_mem [0:4095];
    logic [31:0] hi_mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(12), .BASE_ADDR(32'h0)) dut_lo (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_gnt(lo_m0_gnt), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
        .m0_wdata(m0_wdata), .m0_rvalid(lo_m0_rvalid), .m0_rdata(lo_m0_rdata), .m0_err(lo_m0_err),
        .m1_req(m1_req), .m1_gnt(lo_m1_gnt), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
        .m1_wdata(m1_wdata), .m1_rvalid(lo_m1_rvalid), .m1_rdata(lo_m1_rdata), .m1_err(lo_m1_err),
        .sram_addr(lo_sram_addr), .sram_we(lo_sram_we), .sram_be(lo_sram_be), .sram_d(lo_sram_d),
        .sram_q(lo_q)
    );

    sram_port_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(12), .BASE_ADDR(32'h1000_0000)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_gnt(hi_m0_gnt), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
        .m0_wdata(m0_wdata), .m0_rvalid(hi_m0_rvalid), .m0_rdata(hi_m0_rdata), .m0_err(hi_m0_err),
        .m1_req(m1_req), .m1_gnt(hi_m1_gnt), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
        .m1_wdata(m1_wdata), .m1_rvalid(hi_m1_rvalid), .m1_rdata(hi_m1_rdata), .m1_err(hi_m1_err),
        .sram_addr(hi_sram_addr), .sram_we(hi_sram_we), .sram_be(hi_sram_be), .sram_d(hi_sram_d),
        .sram_q(hi_q)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Write-first SRAM models with a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we && !bd_sel) lo_mem[bd_addr] <= bd_data;
        else if (lo_sram_we) lo_mem[lo_sram_addr] <= merge(lo_mem[lo_sram_addr], lo_sram_d, lo_sram_be);
        lo_q <= lo_sram_we ? merge(lo_mem[lo_sram_addr], lo_sram_d, lo_sram_be) : lo_mem[lo_sram_addr];
    end

    always @(posedge clk) begin
        if (bd_we && bd_sel) hi_mem[bd_addr] <= bd_data;
        else if (hi_sram_we) hi_mem[hi_sram_addr] <= merge(hi_mem[hi_sram_addr], hi_sram_d, hi_sram_be);
        hi_q <= hi_sram_we ? merge(hi_mem[hi_sram_addr], hi_sram_d, hi_sram_be) : hi_mem[hi_sram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of requests just after the rising edge, then wait for the falling edge.
    task automatic step(input logic r0, input logic [31:0] a0, input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        m0_req = r0; m0_addr = a0; m0_we = 1'b0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_be = be1; m1_wdata = d1;
        @(negedge clk);
    endtask

    typedef struct {
        logic        m0_req;
        logic [31:0] m0_addr;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [3:0]  m1_be;
        logic [31:0] m1_wdata;
        logic [1:0]  e_gnt;
        logic [11:0] e_saddr;
        logic        e_we;
        logic [1:0]  e_rv;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] word_exp [8];

    initial begin
        vecs[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   4'h0, 32'h0,         2'b00, 12'h000, 1'b0, 2'b00, 32'h0,         32'h0};
        vecs[1]  = '{1'b1, 32'h14,  1'b0, 1'b0, 32'h0,   4'h0, 32'h0,         2'b01, 12'h005, 1'b0, 2'b00, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 4'h3, 32'h1234_5678, 2'b10, 12'h040, 1'b1, 2'b01, 32'hDEAD_BEEF, 32'h0};
        vecs[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   4'h0, 32'h0,         2'b01, 12'h040, 1'b0, 2'b10, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h14,  4'h0, 32'h0,         2'b10, 12'h005, 1'b0, 2'b01, 32'hFFFF_5678, 32'h0};
        vecs[5]  = '{1'b1, 32'h0,   1'b1, 1'b0, 32'h4,   4'h0, 32'h0,         2'b01, 12'h000, 1'b0, 2'b10, 32'h0,         32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 32'h8,   1'b1, 1'b0, 32'h4,   4'h0, 32'h0,         2'b10, 12'h001, 1'b0, 2'b01, 32'hC0DE_0000, 32'h0};
        vecs[7]  = '{1'b1, 32'h8,   1'b1, 1'b0, 32'hC,   4'h0, 32'h0,         2'b01, 12'h002, 1'b0, 2'b10, 32'h0,         32'hC0DE_0001};
        vecs[8]  = '{1'b1, 32'h10,  1'b1, 1'b0, 32'hC,   4'h0, 32'h0,         2'b10, 12'h003, 1'b0, 2'b01, 32'hC0DE_0002, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   4'h0, 32'h0,         2'b00, 12'h003, 1'b0, 2'b10, 32'h0,         32'hC0DE_0003};
        vecs[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   4'h0, 32'h0,         2'b00, 12'h003, 1'b0, 2'b00, 32'h0,         32'h0};

        for (int i = 0; i < 8; i++) word_exp[i] = (i == 5) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | i);

        rst_n = 1'b0;
        m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_be = '0;   m1_wdata = '0;
        bd_we = 1'b0; bd_sel = 1'b0; bd_addr = '0; bd_data = '0;

        // Backdoor preload while in reset.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bd_we = 1'b1;
            if (i < 8) begin
                bd_sel = 1'b0; bd_addr = 12'(i); bd_data = word_exp[i];
            end else if (i == 8) begin
                bd_sel = 1'b0; bd_addr = 12'h040; bd_data = 32'hFFFF_FFFF;
            end else begin
                bd_sel = 1'b1; bd_addr = 12'h000; bd_data = 32'h5A5A_5A5A;
            end
        end
        @(posedge clk);
        #1;
        bd_we = 1'b0;
        @(negedge clk);
        check("reset m0_rvalid", 32'(lo_m0_rvalid), 32'h0);
        check("reset m1_rvalid", 32'(lo_m1_rvalid), 32'h0);
        check("reset sram_we",   32'(lo_sram_we),   32'h0);
        check("reset sram_addr", 32'(lo_sram_addr), 32'h0);
        check("reset m0_rdata",  lo_m0_rdata,       32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: solo read, write/readback, contention.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].m0_req, vecs[i].m0_addr, vecs[i].m1_req, vecs[i].m1_we,
                 vecs[i].m1_addr, vecs[i].m1_be, vecs[i].m1_wdata);
            check($sformatf("v%0d gnt", i),       32'({lo_m1_gnt, lo_m0_gnt}),       32'(vecs[i].e_gnt));
            check($sformatf("v%0d sram_addr", i), 32'(lo_sram_addr),                 32'(vecs[i].e_saddr));
            check($sformatf("v%0d sram_we", i),   32'(lo_sram_we),                   32'(vecs[i].e_we));
            check($sformatf("v%0d rvalid", i),    32'({lo_m1_rvalid, lo_m0_rvalid}), 32'(vecs[i].e_rv));
            check($sformatf("v%0d m0_rdata", i),  lo_m0_rdata,                       vecs[i].e_rd0);
            check($sformatf("v%0d m1_rdata", i),  lo_m1_rdata,                       vecs[i].e_rd1);
            check($sformatf("v%0d err", i),       32'({lo_m1_err, lo_m0_err}),       32'h0);
        end

        // Range checks on the BASE 0x1000_0000 instance.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h1000_4000, 4'hF, 32'hFFFF_FFFF);
        check("oor wr gnt",     32'(hi_m1_gnt),  32'h1);
        check("oor wr sram_we", 32'(hi_sram_we), 32'h0);
        step(1'b1, 32'h1000_0000, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("oor wr rvalid", 32'(hi_m1_rvalid), 32'h1);
        check("oor wr err",    32'(hi_m1_err),    32'h1);
        check("oor wr rdata",  hi_m1_rdata,       32'h0);
        check("base sram_addr", 32'(hi_sram_addr), 32'h0);
        step(1'b1, 32'h0FFF_FFFC, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("word0 kept",    hi_m0_rdata,       32'h5A5A_5A5A);
        check("word0 err",     32'(hi_m0_err),    32'h0);
        step(1'b1, 32'h1000_3FFC, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("below base rvalid", 32'(hi_m0_rvalid), 32'h1);
        check("below base err",    32'(hi_m0_err),    32'h1);
        check("below base rdata",  hi_m0_rdata,       32'h0);
        check("top word addr",     32'(hi_sram_addr), 32'hFFF);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("top word rvalid", 32'(hi_m0_rvalid), 32'h1);
        check("top word err",    32'(hi_m0_err),    32'h0);

        // Back-to-back reads of words 0..7.
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) step(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            else       step(1'b0, 32'h0,      1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            if (i < 8) check($sformatf("b2b gnt %0d", i), 32'(lo_m0_gnt), 32'h1);
            if (i > 0) begin
                check($sformatf("b2b rvalid %0d", i - 1), 32'(lo_m0_rvalid), 32'h1);
                check($sformatf("b2b rdata %0d", i - 1),  lo_m0_rdata,       word_exp[i - 1]);
            end
        end

        // Reset the cycle after a grant: the response is dropped, rr_last restarts.
        step(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("pre-reset gnt", 32'(lo_m0_gnt), 32'h1);
        @(posedge clk);
        #1;
        m0_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("reset drops rvalid", 32'(lo_m0_rvalid), 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("in reset rvalid %0d", i), 32'({lo_m1_rvalid, lo_m0_rvalid}), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset rvalid", 32'({lo_m1_rvalid, lo_m0_rvalid}), 32'h0);
        step(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        check("post reset tie gnt", 32'({lo_m1_gnt, lo_m0_gnt}), 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        check("post reset rdata", lo_m0_rdata, word_exp[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
